// File: rtl/chan_reader_pkg.sv
// Shared sizing helpers for the chan_reader channel-receive FIFO.
package chan_reader_pkg;

   localparam int MAX_DEPTH = 64;

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int data_w(input int width);
      return (width > 0) ? width : 1;
   endfunction

endpackage

// File: rtl/chan_reader_mem.sv
// Token storage for chan_reader: one synchronous write port, one asynchronous read port, no reset.
module chan_reader_mem #(
   parameter int depth = 4,
   parameter int dw    = 32
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(depth)-1:0] waddr,
   input  logic [dw-1:0]            wdata,
   input  logic [$clog2(depth)-1:0] raddr,
   output logic [dw-1:0]            rdata
);

   logic [dw-1:0] mem [depth];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/chan_reader.sv
// Receiving end of the VALID/CONSUMED channel: buffers tokens for a single-cycle consumer.
// Optional zero-latency empty-FIFO bypass is enabled by defining CHAN_READER_BYPASS_EN.
module chan_reader
   import chan_reader_pkg::*;
#(
   parameter int width = 32,
   parameter int depth = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [data_w(width)-1:0]  IN_READ,
   input  logic                      IN_READ_VALID,
   output logic                      IN_READ_CONSUMED,
   output logic [data_w(width)-1:0]  OUT_DATA,
   output logic                      OUT_NOT_EMPTY,
   input  logic                      OUT_DEQ,
   output logic [ptr_w(depth)-1:0]   OUT_COUNT
);

   localparam int DW = data_w(width);
   localparam int PW = ptr_w(depth);
   localparam int AW = PW - 1;

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          full, empty, enq, pop, bypass;
   logic [DW-1:0] head;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // Full ignores a same-cycle pop, which costs one bubble when draining a full FIFO.
   assign IN_READ_CONSUMED = IN_READ_VALID && !full && !RST;

`ifdef CHAN_READER_BYPASS_EN
   assign bypass = empty && IN_READ_VALID && !RST;
`else
   assign bypass = 1'b0;
`endif

   assign pop = OUT_DEQ && !empty;
   // A bypassed token popped in the same cycle never touches storage.
   assign enq = IN_READ_CONSUMED && !(bypass && OUT_DEQ);

   assign OUT_COUNT     = wr_ptr - rd_ptr;
   assign OUT_NOT_EMPTY = !empty || bypass;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   chan_reader_mem #(
      .depth (depth),
      .dw    (DW)
   ) u_mem (
      .clk   (CLK),
      .we    (enq),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (IN_READ),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (head)
   );

   generate
      if (width == 0) begin : g_token_only
         assign OUT_DATA = '0;
      end else begin : g_data
         always_comb begin
            OUT_DATA = '0;
            if (!empty)      OUT_DATA = head;
            else if (bypass) OUT_DATA = IN_READ;
         end
      end
   endgenerate

endmodule

// File: tb/tb_chan_reader.sv
// Directed self-checking bench for chan_reader (width=32, depth=4).
module tb_chan_reader;

`ifdef CHAN_READER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] IN_READ;
   logic        IN_READ_VALID;
   logic        IN_READ_CONSUMED;
   logic [31:0] OUT_DATA;
   logic        OUT_NOT_EMPTY;
   logic        OUT_DEQ;
   logic [2:0]  OUT_COUNT;

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   chan_reader #(.width(32), .depth(4)) dut (
      .CLK              (CLK),
      .RST              (RST),
      .IN_READ          (IN_READ),
      .IN_READ_VALID    (IN_READ_VALID),
      .IN_READ_CONSUMED (IN_READ_CONSUMED),
      .OUT_DATA         (OUT_DATA),
      .OUT_NOT_EMPTY    (OUT_NOT_EMPTY),
      .OUT_DEQ          (OUT_DEQ),
      .OUT_COUNT        (OUT_COUNT)
   );

   typedef struct {
      logic        valid;
      logic [31:0] din;
      logic        deq;
      logic        cons;
      logic        ne;
      logic [2:0]  cnt;
      logic [31:0] dout;
   } vec_t;

   vec_t vecs[23];

   function automatic vec_t mk(logic v, logic [31:0] d, logic q, logic c,
                               logic n, logic [2:0] k, logic [31:0] o);
      vec_t r;
      r.valid = v; r.din = d; r.deq = q; r.cons = c; r.ne = n; r.cnt = k; r.dout = o;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic q);
      IN_READ_VALID = v;
      IN_READ       = d;
      OUT_DEQ       = q;
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   logic       exp_ne;
   logic [31:0] exp_do;

   initial begin
      RST = 1'b1;
      drive(1'b0, 32'h0, 1'b0);

      // Token-by-token table; bypass only alters empty+valid rows with deq low.
      vecs[0]  = mk(0, 32'h00, 0, 0, 0, 3'd0, 32'h00);
      vecs[1]  = mk(1, 32'h11, 0, 1, 0, 3'd0, 32'h00);
      vecs[2]  = mk(1, 32'h22, 0, 1, 1, 3'd1, 32'h11);
      vecs[3]  = mk(1, 32'h33, 0, 1, 1, 3'd2, 32'h11);
      vecs[4]  = mk(0, 32'h00, 1, 0, 1, 3'd3, 32'h11);
      vecs[5]  = mk(0, 32'h00, 1, 0, 1, 3'd2, 32'h22);
      vecs[6]  = mk(0, 32'h00, 1, 0, 1, 3'd1, 32'h33);
      vecs[7]  = mk(0, 32'h00, 0, 0, 0, 3'd0, 32'h00);
      vecs[8]  = mk(1, 32'hA0, 0, 1, 0, 3'd0, 32'h00);
      vecs[9]  = mk(1, 32'hA1, 0, 1, 1, 3'd1, 32'hA0);
      vecs[10] = mk(1, 32'hA2, 0, 1, 1, 3'd2, 32'hA0);
      vecs[11] = mk(1, 32'hA3, 0, 1, 1, 3'd3, 32'hA0);
      vecs[12] = mk(1, 32'hA4, 0, 0, 1, 3'd4, 32'hA0);
      vecs[13] = mk(1, 32'hA4, 1, 0, 1, 3'd4, 32'hA0);
      vecs[14] = mk(1, 32'hA4, 0, 1, 1, 3'd3, 32'hA1);
      vecs[15] = mk(0, 32'h00, 0, 0, 1, 3'd4, 32'hA1);
      vecs[16] = mk(0, 32'h00, 1, 0, 1, 3'd4, 32'hA1);
      vecs[17] = mk(0, 32'h00, 1, 0, 1, 3'd3, 32'hA2);
      vecs[18] = mk(0, 32'h00, 1, 0, 1, 3'd2, 32'hA3);
      vecs[19] = mk(0, 32'h00, 1, 0, 1, 3'd1, 32'hA4);
      vecs[20] = mk(0, 32'h00, 0, 0, 0, 3'd0, 32'h00);
      vecs[21] = mk(0, 32'h00, 1, 0, 0, 3'd0, 32'h00);
      vecs[22] = mk(0, 32'h00, 0, 0, 0, 3'd0, 32'h00);

      next_cycle();
      next_cycle();
      RST = 1'b0;
      #2;
      chk("reset_not_empty", {31'b0, OUT_NOT_EMPTY}, 32'd0);
      chk("reset_count",     {29'b0, OUT_COUNT},     32'd0);
      chk("reset_data",      OUT_DATA,               32'd0);
      chk("reset_consumed",  {31'b0, IN_READ_CONSUMED}, 32'd0);
      next_cycle();

      for (int i = 0; i < 23; i++) begin
         drive(vecs[i].valid, vecs[i].din, vecs[i].deq);
         #2;
         exp_ne = vecs[i].ne;
         exp_do = vecs[i].dout;
         if (BYP && vecs[i].cnt == 3'd0 && vecs[i].valid) begin
            exp_ne = 1'b1;
            exp_do = vecs[i].din;
         end
         chk($sformatf("vec%0d_consumed", i), {31'b0, IN_READ_CONSUMED}, {31'b0, vecs[i].cons});
         chk($sformatf("vec%0d_not_empty", i), {31'b0, OUT_NOT_EMPTY}, {31'b0, exp_ne});
         chk($sformatf("vec%0d_count", i), {29'b0, OUT_COUNT}, {29'b0, vecs[i].cnt});
         chk($sformatf("vec%0d_data", i), OUT_DATA, exp_do);
         next_cycle();
      end

      // Concurrent enq+pop across pointer wrap: occupancy must hold at 1.
      drive(1'b1, 32'hB00, 1'b0);
      next_cycle();
      for (int i = 1; i <= 20; i++) begin
         drive(1'b1, 32'hB00 + i, 1'b1);
         #2;
         chk($sformatf("stream%0d_count", i), {29'b0, OUT_COUNT}, 32'd1);
         chk($sformatf("stream%0d_data", i), OUT_DATA, 32'hB00 + i - 1);
         chk($sformatf("stream%0d_consumed", i), {31'b0, IN_READ_CONSUMED}, 32'd1);
         next_cycle();
      end
      drive(1'b0, 32'h0, 1'b1);
      #2;
      chk("stream_tail_data", OUT_DATA, 32'hB14);
      next_cycle();
      drive(1'b0, 32'h0, 1'b0);
      #2;
      chk("stream_drained", {29'b0, OUT_COUNT}, 32'd0);
      next_cycle();

      // Mid-operation reset with a token held on the channel.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'hC0 + i, 1'b0);
         next_cycle();
      end
      drive(1'b1, 32'hC3, 1'b0);
      #1;
      chk("prerst_count", {29'b0, OUT_COUNT}, 32'd3);
      RST = 1'b1;
      #1;
      chk("rst_async_count",     {29'b0, OUT_COUNT},        32'd0);
      chk("rst_async_not_empty", {31'b0, OUT_NOT_EMPTY},    32'd0);
      chk("rst_async_data",      OUT_DATA,                  32'd0);
      chk("rst_consumed",        {31'b0, IN_READ_CONSUMED}, 32'd0);
      next_cycle();
      #2;
      chk("rst_held_consumed", {31'b0, IN_READ_CONSUMED}, 32'd0);
      chk("rst_held_count",    {29'b0, OUT_COUNT},        32'd0);
      next_cycle();
      RST = 1'b0;
      #1;
      chk("postrst_consumed", {31'b0, IN_READ_CONSUMED}, 32'd1);
      next_cycle();
      drive(1'b0, 32'h0, 1'b0);
      #1;
      chk("postrst_count", {29'b0, OUT_COUNT}, 32'd1);
      chk("postrst_data",  OUT_DATA,           32'hC3);
      drive(1'b0, 32'h0, 1'b1);
      next_cycle();
      drive(1'b0, 32'h0, 1'b0);
      next_cycle();

      // Empty FIFO, token offered and popped in the same cycle.
      drive(1'b1, 32'h5A, 1'b1);
      #2;
      chk("byp_consumed",  {31'b0, IN_READ_CONSUMED}, 32'd1);
      chk("byp_not_empty", {31'b0, OUT_NOT_EMPTY},    BYP ? 32'd1 : 32'd0);
      chk("byp_data",      OUT_DATA,                  BYP ? 32'h5A : 32'h0);
      next_cycle();
      drive(1'b0, 32'h0, 1'b0);
      #2;
      chk("byp_next_count",     {29'b0, OUT_COUNT},     BYP ? 32'd0 : 32'd1);
      chk("byp_next_not_empty", {31'b0, OUT_NOT_EMPTY}, BYP ? 32'd0 : 32'd1);
      chk("byp_next_data",      OUT_DATA,               BYP ? 32'h0 : 32'h5A);
      drive(1'b0, 32'h0, 1'b1);
      next_cycle();
      drive(1'b0, 32'h0, 1'b0);
      #2;
      chk("final_count", {29'b0, OUT_COUNT}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
